// File: rtl/mmu_mem_arbiter.sv
// mmu_mem_arbiter: shares one memory bus between MMU page-table reads and CPU data accesses,
// with fixed PT priority and a per-access ack timeout.
module mmu_mem_arbiter #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] pt_addr,
  input  logic        pt_read,
  output logic [7:0]  pt_data,
  output logic        pt_ready,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_read,
  input  logic        cpu_write,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_xlat_ok,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_ready,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  output logic        bus_error
);
  typedef enum logic [1:0] {IDLE, PT_BUS, CPU_BUS, DONE} state_e;
  state_e      state_q;
  logic        pt_pend_q, cpu_own_q, mem_rd_q, mem_wr_q, pt_ready_q, cpu_ready_q, bus_error_q;
  logic [7:0]  cnt_q, pt_data_q, cpu_rdata_q, mem_wdata_q;
  logic [15:0] mem_addr_q;
  logic [7:0]  cnt_d, rdata_d;
  logic        timeout;
  // Ack wins over a simultaneous timeout, so the timeout only fires on an ack-free cycle.
  always_comb begin
    cnt_d   = cnt_q + 8'd1;
    timeout = !mem_ack && (cnt_d == 8'(TIMEOUT_CYCLES));
    rdata_d = mem_ack ? mem_rdata : 8'hFF;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q     <= IDLE;
      pt_pend_q   <= 1'b0;
      cpu_own_q   <= 1'b0;
      cnt_q       <= 8'h00;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= 16'h0000;
      mem_wdata_q <= 8'h00;
      pt_data_q   <= 8'h00;
      cpu_rdata_q <= 8'h00;
      pt_ready_q  <= 1'b0;
      cpu_ready_q <= 1'b0;
      bus_error_q <= 1'b0;
    end else begin
      pt_ready_q  <= 1'b0;
      cpu_ready_q <= 1'b0;
      bus_error_q <= 1'b0;
      if (pt_read) pt_pend_q <= 1'b1;
      case (state_q)
        IDLE:
          if (pt_pend_q || pt_read) begin
            state_q    <= PT_BUS;
            pt_pend_q  <= 1'b0;
            cpu_own_q  <= 1'b0;
            cnt_q      <= 8'h00;
            mem_addr_q <= pt_addr;
            mem_rd_q   <= 1'b1;
            mem_wr_q   <= 1'b0;
          end else if ((cpu_read || cpu_write) && cpu_xlat_ok) begin
            state_q     <= CPU_BUS;
            cpu_own_q   <= 1'b1;
            cnt_q       <= 8'h00;
            mem_addr_q  <= cpu_addr;
            mem_wdata_q <= cpu_wdata;
            mem_rd_q    <= !cpu_write;
            mem_wr_q    <= cpu_write;
          end
        PT_BUS, CPU_BUS: begin
          cnt_q <= mem_ack ? cnt_q : cnt_d;
          if (mem_ack || timeout) begin
            state_q     <= DONE;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            pt_ready_q  <= !cpu_own_q;
            cpu_ready_q <= cpu_own_q;
            bus_error_q <= timeout;
            if (mem_rd_q && cpu_own_q) cpu_rdata_q <= rdata_d;
            if (mem_rd_q && !cpu_own_q) pt_data_q <= rdata_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  assign pt_data   = pt_data_q;
  assign pt_ready  = pt_ready_q;
  assign cpu_rdata = cpu_rdata_q;
  assign cpu_ready = cpu_ready_q;
  assign mem_addr  = mem_addr_q;
  assign mem_rd    = mem_rd_q;
  assign mem_wr    = mem_wr_q;
  assign mem_wdata = mem_wdata_q;
  assign bus_error = bus_error_q;
endmodule

// File: tb/tb_mmu_mem_arbiter.sv
// tb_mmu_mem_arbiter: directed checks of arbitration, completion, timeout, gating and reset.
module tb_mmu_mem_arbiter;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic [15:0] pt_addr = '0, cpu_addr = '0;
  logic        pt_read = 1'b0, cpu_read = 1'b0, cpu_write = 1'b0, cpu_xlat_ok = 1'b1, mem_ack = 1'b0;
  logic [7:0]  cpu_wdata = '0, mem_rdata = '0;
  logic [7:0]  pt_data, cpu_rdata, mem_wdata;
  logic [15:0] mem_addr;
  logic        pt_ready, cpu_ready, mem_rd, mem_wr, bus_error;
  int tests = 0, fails = 0;
  logic seen;

  mmu_mem_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .pt_addr(pt_addr), .pt_read(pt_read), .pt_data(pt_data),
    .pt_ready(pt_ready), .cpu_addr(cpu_addr), .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_wdata(cpu_wdata), .cpu_xlat_ok(cpu_xlat_ok), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    tick;
    tick;
    chk("rst_strobes", {30'b0, mem_rd, mem_wr}, 0);
    chk("rst_addr", 32'(mem_addr), 32'h0000);
    chk("rst_data", {8'b0, pt_data, cpu_rdata, mem_wdata}, 0);
    chk("rst_pulses", {29'b0, pt_ready, cpu_ready, bus_error}, 0);
    rst_n = 1'b1;
    tick;
    // PT read, ack on the 4th bus cycle (same cycle the counter hits the limit)
    pt_addr = 16'h1234; pt_read = 1'b1;
    tick;
    pt_read = 1'b0;
    chk("pt_launch_rd", 32'(mem_rd), 1);
    chk("pt_launch_addr", 32'(mem_addr), 32'h1234);
    tick; tick; tick;
    chk("pt_wait_rd", 32'(mem_rd), 1);
    mem_ack = 1'b1; mem_rdata = 8'hA5;
    tick;
    mem_ack = 1'b0;
    chk("pt_ready", {30'b0, pt_ready, cpu_ready}, 32'b10);
    chk("pt_no_err", 32'(bus_error), 0);
    chk("pt_data", 32'(pt_data), 32'hA5);
    chk("pt_strobe_drop", 32'(mem_rd), 0);
    tick;
    chk("pt_ready_pulse", 32'(pt_ready), 0);
    chk("pt_data_held", 32'(pt_data), 32'hA5);
    // Contention: PT beats a simultaneous CPU read
    cpu_read = 1'b1; cpu_addr = 16'h2000; pt_read = 1'b1; pt_addr = 16'h0040;
    tick;
    pt_read = 1'b0;
    chk("cont_pt_first", 32'(mem_addr), 32'h0040);
    mem_ack = 1'b1; mem_rdata = 8'h11;
    tick;
    mem_ack = 1'b0;
    chk("cont_pt_ready", {30'b0, pt_ready, cpu_ready}, 32'b10);
    tick;
    chk("cont_no_launch_done", {30'b0, mem_rd, mem_wr}, 0);
    tick;
    chk("cont_cpu_launch", {15'b0, mem_rd, mem_addr}, {15'b0, 1'b1, 16'h2000});
    mem_ack = 1'b1; mem_rdata = 8'h22;
    tick;
    mem_ack = 1'b0; cpu_read = 1'b0;
    chk("cont_cpu_ready", {30'b0, pt_ready, cpu_ready}, 32'b01);
    chk("cont_rdata", {16'b0, pt_data, cpu_rdata}, 32'h1122);
    tick;
    chk("cont_idle", 32'(cpu_ready), 0);
    // CPU write with read also high: write wins
    cpu_write = 1'b1; cpu_read = 1'b1; cpu_wdata = 8'h5A; cpu_addr = 16'h3001;
    tick;
    chk("wr_strobes", {30'b0, mem_rd, mem_wr}, 32'b01);
    chk("wr_bus", {8'b0, mem_addr, mem_wdata}, {8'b0, 16'h3001, 8'h5A});
    tick;
    chk("wr_wait", {31'b0, cpu_ready}, 0);
    mem_ack = 1'b1;
    tick;
    mem_ack = 1'b0; cpu_write = 1'b0; cpu_read = 1'b0;
    chk("wr_ready", {30'b0, mem_wr, cpu_ready}, 32'b01);
    chk("wr_rdata_kept", 32'(cpu_rdata), 32'h22);
    tick;
    chk("wr_single", {30'b0, mem_wr, cpu_ready}, 0);
    // Timeout: no ack for 4 bus cycles
    cpu_read = 1'b1; cpu_addr = 16'h4000;
    tick;
    chk("to_launch", 32'(mem_rd), 1);
    tick; tick; tick;
    chk("to_cycle4", 32'(mem_rd), 1);
    tick;
    cpu_read = 1'b0;
    chk("to_done", {29'b0, mem_rd, cpu_ready, bus_error}, 32'b011);
    chk("to_rdata", 32'(cpu_rdata), 32'hFF);
    tick;
    chk("to_err_pulse", {30'b0, cpu_ready, bus_error}, 0);
    // Gating: untranslated CPU request never reaches the bus
    cpu_read = 1'b1; cpu_xlat_ok = 1'b0; seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick;
      seen |= mem_rd | mem_wr | cpu_ready;
    end
    chk("gate_blocked", 32'(seen), 0);
    cpu_read = 1'b0; cpu_xlat_ok = 1'b1;
    // mem_ack in IDLE is ignored
    mem_ack = 1'b1;
    tick;
    mem_ack = 1'b0;
    chk("ack_idle_ignored", {29'b0, pt_ready, cpu_ready, mem_rd}, 0);
    // xlat drops mid-access (no abort); pt_read during CPU_BUS becomes pending
    cpu_read = 1'b1; cpu_addr = 16'h5000;
    tick;
    cpu_xlat_ok = 1'b0; pt_read = 1'b1; pt_addr = 16'h0077;
    tick;
    pt_read = 1'b0;
    chk("xlat_drop_held", 32'(mem_rd), 1);
    mem_ack = 1'b1; mem_rdata = 8'h33;
    tick;
    mem_ack = 1'b0; cpu_read = 1'b0; cpu_xlat_ok = 1'b1;
    chk("xlat_drop_ready", {23'b0, cpu_ready, cpu_rdata}, {23'b0, 1'b1, 8'h33});
    tick;
    tick;
    chk("pend_launch", {15'b0, mem_rd, mem_addr}, {15'b0, 1'b1, 16'h0077});
    mem_ack = 1'b1; mem_rdata = 8'h44;
    tick;
    mem_ack = 1'b0;
    chk("pend_ready", {23'b0, pt_ready, pt_data}, {23'b0, 1'b1, 8'h44});
    tick; tick;
    chk("pend_cleared", 32'(mem_rd), 0);
    // Reset mid-access
    pt_read = 1'b1; pt_addr = 16'h0900;
    tick;
    pt_read = 1'b0;
    chk("rst_mid_rd", 32'(mem_rd), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_drop", {30'b0, mem_rd, mem_wr}, 0);
    tick;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick;
      seen |= pt_ready | cpu_ready | mem_rd | mem_wr;
    end
    chk("rst_abandon", 32'(seen), 0);
    chk("rst_pt_data", 32'(pt_data), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mmu_mem_arbiter.md
MMU_MEM_ARBITER -- requirements
Module: mmu_mem_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 15, meaning max cycles a bus access waits for mem_ack before abort (range 1..255).
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 pt_addr  input  16  MMU page-table entry address.
REQ-005 pt_read  input  1  MMU page-table read request, single-cycle pulse.
REQ-006 pt_data  output  8  page-table read data.
REQ-007 pt_ready  output  1  page-table read complete, single-cycle pulse.
REQ-008 cpu_addr  input  16  translated physical address from MMU.
REQ-009 cpu_read / cpu_write  input  1 each  CPU data access request, level, held until cpu_ready.
REQ-010 cpu_wdata  input  8  CPU write data.
REQ-011 cpu_xlat_ok  input  1  MMU translation_valid; CPU request eligible only when high.
REQ-012 cpu_rdata  output  8  CPU read data.
REQ-013 cpu_ready  output  1  CPU access complete, single-cycle pulse.
REQ-014 mem_addr  output  16  memory bus address.
REQ-015 mem_rd / mem_wr  output  1 each  memory bus strobes, held for whole access.
REQ-016 mem_wdata  output  8  memory bus write data.
REQ-017 mem_rdata  input  8  memory bus read data.
REQ-018 mem_ack  input  1  memory bus completion, sampled each cycle.
REQ-019 bus_error  output  1  single-cycle pulse coincident with ready on a timed-out access.

Function
REQ-020 FSM states: IDLE, PT_BUS, CPU_BUS, DONE.
REQ-021 pt_read pulse sets a pt_pending flag in any state; flag clears when IDLE launches the PT access; a pt_read while pt_pending is already set is ignored.
REQ-022 IDLE arbitration: pt_pending (or pt_read this cycle) -> PT_BUS; else (cpu_read|cpu_write)&cpu_xlat_ok -> CPU_BUS; else stay. PT has fixed priority.
REQ-023 On leaving IDLE, mem_addr/mem_wdata/direction are registered; mem_rd or mem_wr asserts the next cycle (launch latency 1 cycle from request seen in IDLE).
REQ-024 PT access is always a read; cpu_write and cpu_read both high -> write.
REQ-025 In PT_BUS/CPU_BUS, mem_ack high -> capture mem_rdata (reads) into pt_data or cpu_rdata, drop strobes, go to DONE.
REQ-026 DONE lasts exactly one cycle: pt_ready or cpu_ready (matching owner) high in DONE, then -> IDLE; no new launch in DONE.
REQ-027 Read completion latency: ready pulse the cycle after mem_ack.
REQ-028 pt_data and cpu_rdata hold their value until overwritten by the next completed read of the same owner.
REQ-029 Timeout counter (8-bit) clears on launch, increments each bus-state cycle without mem_ack; reaching TIMEOUT_CYCLES -> drop strobes, load 8'hFF into the owner's read data (reads only), go to DONE, pulse bus_error with ready.
REQ-030 mem_ack in the same cycle the counter reaches TIMEOUT_CYCLES -> treated as normal completion, no bus_error.
REQ-031 mem_ack in IDLE or DONE is ignored.
REQ-032 cpu_xlat_ok low with CPU request pending -> no bus access, no cpu_ready; arbiter stays IDLE.
REQ-033 cpu_xlat_ok falling during CPU_BUS does not abort the access.

Reset
REQ-034 Asynchronous reset: state IDLE, pt_pending 0, counter 0, mem_rd/mem_wr/pt_ready/cpu_ready/bus_error 0, mem_addr 16'h0000, mem_wdata/pt_data/cpu_rdata 8'h00.
REQ-035 Reset mid-access abandons it immediately; strobes drop asynchronously; no ready is issued after release.

Verification
REQ-036 PT read: pt_read pulse, pt_addr=16'h1234, mem_ack 3 cycles after mem_rd with mem_rdata=8'hA5 -> mem_addr=16'h1234, pt_ready pulse next cycle, pt_data=8'hA5 held.
REQ-037 Contention: cpu_read held (cpu_addr=16'h2000, xlat_ok=1) same cycle as pt_read -> PT access first, then CPU access; cpu_ready only after pt_ready, no back-to-back launch in DONE.
REQ-038 CPU write: cpu_write, cpu_wdata=8'h5A, cpu_addr=16'h3001, ack after 1 cycle -> mem_wr with 16'h3001/8'h5A, one cpu_ready, single strobe episode.
REQ-039 Timeout: TIMEOUT_CYCLES=4, cpu_read, no ack -> strobes drop after 4 bus cycles, cpu_rdata=8'hFF, cpu_ready and bus_error pulse together.
REQ-040 Gating: cpu_read with cpu_xlat_ok=0 for 10 cycles -> mem_rd never asserts, no cpu_ready.
REQ-041 Reset mid-access: rst_n low during PT_BUS -> strobes 0 immediately; after release, IDLE, no pt_ready, pt_pending 0.
